store_buffer: RTL and testbench



---
 rtl/store_buffer.sv | 187 ++++++++++++++++++
 tb/tb_store_buffer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write store buffer for the RV32I MEM stage.
//
// Checks store alignment, converts SB/SH/SW stores into a word address,
// lane-shifted data and byte strobes, queues them in a DEPTH-entry FIFO and
// drains them in order to data memory over a req/ack handshake. A
// combinational word-address compare lets the load path stall on pending stores.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid/in_ready     store request handshake (in_ready = !full)
//   in_addr/in_data/in_sel byte address, formatted value, size (00 SB, 01 SH, 1x SW)
//   misalign              one-cycle pulse after a rejected misaligned store
//   mem_req/mem_ack       write request to memory and its acknowledge
//   mem_addr/mem_wdata/mem_wstrb  head entry (zero while idle)
//   chk_addr/chk_hit      load address and pending same-word hit
//   count/empty/full      occupancy
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_addr,
    input  logic [31:0]            in_data,
    input  logic [1:0]             in_sel,
    output logic                   misalign,
    output logic                   mem_req,
    output logic [AW-1:0]          mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_wstrb,
    input  logic                   mem_ack,
    input  logic [AW-1:0]          chk_addr,
    output logic                   chk_hit,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          misalign_q;

    // Entries hold the word address only; the byte offset lives in the strobes.
    logic [AW-3:0] addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    strb_mem [DEPTH];

    logic          aligned;
    logic          push, pop, reject;
    logic [31:0]   fmt_data;
    logic [3:0]    fmt_strb;
    logic          chk_lsb_unused;

    assign chk_lsb_unused = ^chk_addr[1:0];

    assign full     = (count_q == FullCount);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign in_ready = !full;
    assign misalign = misalign_q;

    always_comb begin
        aligned = 1'b1;
        if (in_sel[1]) begin
            aligned = (in_addr[1:0] == 2'b00);
        end else if (in_sel[0]) begin
            aligned = !in_addr[0];
        end
    end

    assign push   = in_valid && in_ready && aligned;
    assign reject = in_valid && in_ready && !aligned;
    assign pop    = (state_q == StReq) && mem_ack;

    // Lane formatting; unused lanes are forced to zero.
    always_comb begin
        fmt_data = 32'h0;
        fmt_strb = 4'b0000;
        if (in_sel[1]) begin
            fmt_data = in_data;
            fmt_strb = 4'b1111;
        end else if (in_sel[0]) begin
            if (in_addr[1]) begin
                fmt_data = {in_data[15:0], 16'h0};
                fmt_strb = 4'b1100;
            end else begin
                fmt_data = {16'h0, in_data[15:0]};
                fmt_strb = 4'b0011;
            end
        end else begin
            unique case (in_addr[1:0])
                2'b00: begin fmt_data = {24'h0, in_data[7:0]};        fmt_strb = 4'b0001; end
                2'b01: begin fmt_data = {16'h0, in_data[7:0], 8'h0};  fmt_strb = 4'b0010; end
                2'b10: begin fmt_data = {8'h0, in_data[7:0], 16'h0};  fmt_strb = 4'b0100; end
                default: begin fmt_data = {in_data[7:0], 24'h0};      fmt_strb = 4'b1000; end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Drain FSM and memory-side outputs.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'b0000;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                mem_req   = 1'b1;
                mem_addr  = {addr_mem[rd_ptr_q], 2'b00};
                mem_wdata = data_mem[rd_ptr_q];
                mem_wstrb = strb_mem[rd_ptr_q];
                // Stay in REQ for back-to-back drain while anything remains.
                if (pop && (count_d == '0)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // An entry is valid when its distance from the head is below count.
    always_comb begin
        logic [PW-1:0] off;
        chk_hit = 1'b0;
        off     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) && (addr_mem[i] == chk_addr[AW-1:2])) begin
                chk_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            misalign_q <= reject;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage needs no reset: validity is defined by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= in_addr[AW-1:2];
            data_mem[wr_ptr_q] <= fmt_data;
            strb_mem[wr_ptr_q] <= fmt_strb;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed bench for store_buffer with a queue-based
// reference model checked every cycle plus hand-computed literal checks.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_data;
    logic [1:0]    in_sel;
    logic          misalign;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ack;
    logic [AW-1:0] chk_addr;
    logic          chk_hit;
    logic [2:0]    count;
    logic          empty;
    logic          full;

    store_buffer #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .misalign (misalign),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ack  (mem_ack),
        .chk_addr (chk_addr),
        .chk_hit  (chk_hit),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    ent_t m_q[$];
    logic m_req = 1'b0;
    logic m_mis = 1'b0;

    function automatic logic is_aligned(input logic [31:0] a, input logic [1:0] sel);
        if (sel[1]) return a[1:0] == 2'b00;
        if (sel[0]) return a[0] == 1'b0;
        return 1'b1;
    endfunction

    function automatic ent_t fmt(input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] sel);
        ent_t        e;
        int          o;
        logic [3:0]  s;
        logic [31:0] v;
        o      = int'(a[1:0]);
        e.addr = a & ~32'h3;
        if (sel[1]) begin
            e.strb = 4'hF;
            e.data = d;
        end else if (sel[0]) begin
            s      = 4'b0011;
            v      = d & 32'h0000_FFFF;
            e.strb = s << (2 * (o / 2));
            e.data = v << (16 * (o / 2));
        end else begin
            s      = 4'b0001;
            v      = d & 32'h0000_00FF;
            e.strb = s << o;
            e.data = v << (8 * o);
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_req <= 1'b0;
            m_mis <= 1'b0;
        end else begin
            int   sz;
            logic rdy, do_pop;
            sz     = m_q.size();
            rdy    = (sz < DEPTH);
            do_pop = m_req && mem_ack;
            m_mis <= in_valid && rdy && !is_aligned(in_addr, in_sel);
            if (do_pop) void'(m_q.pop_front());
            if (in_valid && rdy && is_aligned(in_addr, in_sel)) begin
                m_q.push_back(fmt(in_addr, in_data, in_sel));
            end
            if (m_req) m_req <= do_pop ? (m_q.size() > 0) : 1'b1;
            else       m_req <= (sz > 0);
        end
    end

    function automatic logic model_hit(input logic [31:0] a);
        foreach (m_q[i]) begin
            if (m_q[i].addr[31:2] == a[31:2]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            int sz;
            sz = m_q.size();
            check("cyc_count", 32'(count), 32'(sz));
            check("cyc_empty", 32'(empty), 32'(sz == 0));
            check("cyc_full", 32'(full), 32'(sz == DEPTH));
            check("cyc_in_ready", 32'(in_ready), 32'(sz != DEPTH));
            check("cyc_misalign", 32'(misalign), 32'(m_mis));
            check("cyc_chk_hit", 32'(chk_hit), 32'(model_hit(chk_addr)));
            check("cyc_mem_req", 32'(mem_req), 32'(m_req));
            if (m_req && sz > 0) begin
                check("cyc_mem_addr", mem_addr, m_q[0].addr);
                check("cyc_mem_wdata", mem_wdata, m_q[0].data);
                check("cyc_mem_wstrb", 32'(mem_wstrb), 32'(m_q[0].strb));
            end else begin
                check("cyc_mem_addr_idle", mem_addr, 32'h0);
                check("cyc_mem_wdata_idle", mem_wdata, 32'h0);
                check("cyc_mem_wstrb_idle", 32'(mem_wstrb), 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; in_sel = 2'b00;
        mem_ack = 1'b0; chk_addr = '0;
        #2;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_misalign", 32'(misalign), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        check("rst_chk_hit", 32'(chk_hit), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: SB at 0x1003
        in_valid = 1'b1; in_addr = 32'h1003; in_data = 32'h0000_00AB; in_sel = 2'b00;
        chk_addr = 32'h1000;
        #1 check("t1_hit_before_accept", 32'(chk_hit), 32'h0);
        tick();
        in_valid = 1'b0;
        #1;
        check("t1_req_after_T", 32'(mem_req), 32'h0);
        check("t1_count", 32'(count), 32'h1);
        check("t1_hit_after_accept", 32'(chk_hit), 32'h1);
        tick();
        check("t1_req_after_T1", 32'(mem_req), 32'h1);
        check("t1_addr", mem_addr, 32'h0000_1000);
        check("t1_wdata", mem_wdata, 32'hAB00_0000);
        check("t1_wstrb", 32'(mem_wstrb), 32'h8);
        check("t1_model_wdata", m_q[0].data, 32'hAB00_0000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        check("t1_empty_after_pop", 32'(empty), 32'h1);
        check("t1_req_after_pop", 32'(mem_req), 32'h0);

        // 2: SH aligned, then SH misaligned
        in_valid = 1'b1; in_addr = 32'h2002; in_data = 32'h0000_BEEF; in_sel = 2'b01;
        tick();
        in_valid = 1'b0;
        tick();
        check("t2_wdata", mem_wdata, 32'hBEEF_0000);
        check("t2_wstrb", 32'(mem_wstrb), 32'hC);
        check("t2_model_strb", 32'(m_q[0].strb), 32'hC);
        in_valid = 1'b1; in_addr = 32'h2001;
        tick();
        in_valid = 1'b0;
        #1;
        check("t2_misalign_pulse", 32'(misalign), 32'h1);
        check("t2_count_unchanged", 32'(count), 32'h1);
        tick();
        check("t2_misalign_cleared", 32'(misalign), 32'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();

        // 3: fill with four SW while memory stalls
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_addr = 32'h10 + 32'(4 * k); in_sel = 2'b10;
            in_data = 32'h1111_1111 * 32'(k + 1);
            tick();
        end
        #1;
        check("t3_full", 32'(full), 32'h1);
        check("t3_in_ready", 32'(in_ready), 32'h0);
        check("t3_count", 32'(count), 32'h4);
        in_addr = 32'h20; in_data = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0;
        #1;
        check("t3_fifth_ignored", 32'(count), 32'h4);
        check("t3_head_addr", mem_addr, 32'h10);

        // 4: drain back-to-back
        mem_ack = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("t4_req", 32'(mem_req), 32'h1);
            check("t4_addr", mem_addr, 32'h10 + 32'(4 * k));
            check("t4_wdata", mem_wdata, 32'h1111_1111 * 32'(k + 1));
            tick();
        end
        mem_ack = 1'b0;
        #1;
        check("t4_idle_req", 32'(mem_req), 32'h0);
        check("t4_empty", 32'(empty), 32'h1);

        // 5: address-hit check
        in_valid = 1'b1; in_addr = 32'h40; in_data = 32'hCAFE_F00D; in_sel = 2'b10;
        tick();
        in_valid = 1'b0;
        chk_addr = 32'h43;
        #1 check("t5_hit_43", 32'(chk_hit), 32'h1);
        chk_addr = 32'h44;
        #1 check("t5_miss_44", 32'(chk_hit), 32'h0);
        tick();
        chk_addr = 32'h43;
        #1 check("t5_hit_head_in_req", 32'(chk_hit), 32'h1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1 check("t5_miss_after_ack", 32'(chk_hit), 32'h0);

        // 6: reset while requesting with three entries
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_addr = 32'h80 + 32'(4 * k); in_sel = 2'b10;
            in_data = 32'hA5A5_0000 + 32'(k);
            tick();
        end
        in_valid = 1'b0;
        chk_addr = 32'h80;
        #1 check("t6_req_before_rst", 32'(mem_req), 32'h1);
        rst = 1'b1;
        #1;
        check("t6_req_dropped", 32'(mem_req), 32'h0);
        check("t6_count", 32'(count), 32'h0);
        check("t6_empty", 32'(empty), 32'h1);
        check("t6_hit_cleared", 32'(chk_hit), 32'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_no_replay", 32'(mem_req), 32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
